// File: rtl/flood_open_ctrl.sv
// Flood-fill sequencer for a minesweeper "open": walks a LIFO stack of coordinates,
// reads board value + cover state per cell, issues one open write per covered cell.
module flood_open_ctrl #(
   parameter int X_SIZE      = 16,
   parameter int Y_SIZE      = 16,
   parameter int X_BITS      = 4,
   parameter int Y_BITS      = 4,
   parameter int STACK_DEPTH = 64,
   parameter int STACK_AW    = 6
) (
   input  logic                     board_clk,
   input  logic                     glob_reset,
   input  logic                     i_start,
   input  logic                     i_cancel,
   input  logic [X_BITS-1:0]        i_start_x,
   input  logic [Y_BITS-1:0]        i_start_y,
   output logic                     o_rd_en,
   output logic [X_BITS-1:0]        o_rd_x,
   output logic [Y_BITS-1:0]        o_rd_y,
   input  logic [4:0]               i_rd_board_val,
   input  logic [1:0]               i_rd_cover_val,
   output logic                     o_open_strobe,
   output logic [X_BITS-1:0]        o_open_x,
   output logic [Y_BITS-1:0]        o_open_y,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_hit_mine,
   output logic                     o_overflow,
   output logic [X_BITS+Y_BITS:0]   o_opened_count
);

   localparam int                SW     = X_BITS + Y_BITS;
   localparam int                CW     = X_BITS + Y_BITS + 1;
   localparam logic [X_BITS+1:0] X_LIM  = (X_BITS+2)'(X_SIZE);
   localparam logic [Y_BITS+1:0] Y_LIM  = (Y_BITS+2)'(Y_SIZE);
   localparam logic [STACK_AW:0] SP_FULL = (STACK_AW+1)'(STACK_DEPTH);
   localparam logic [4:0]        MINE_VAL = 5'h1F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_WAIT,
      S_EVAL,
      S_NBR,
      S_FIN
   } state_t;

   state_t              r_state;
   logic [SW-1:0]       r_stack [STACK_DEPTH];
   logic [STACK_AW:0]   r_sp;
   logic [X_BITS-1:0]   r_cur_x;
   logic [Y_BITS-1:0]   r_cur_y;
   logic [2:0]          r_nbr_idx;

   logic [X_BITS+1:0]   w_dx;
   logic [X_BITS+1:0]   w_nx;
   logic [Y_BITS+1:0]   w_dy;
   logic [Y_BITS+1:0]   w_ny;
   logic                w_nbr_ok;
   logic                w_full;
   logic                w_push_en;
   logic [STACK_AW-1:0] w_push_addr;
   logic [SW-1:0]       w_push_data;
   logic [STACK_AW-1:0] w_top_addr;
   logic [SW-1:0]       w_top;

   assign w_full     = (r_sp == SP_FULL);
   assign w_top_addr = r_sp[STACK_AW-1:0] - STACK_AW'(1);
   assign w_top      = r_stack[w_top_addr];

   // Neighbour offsets are added with two guard bits: a -1 step from column 0
   // wraps to a large unsigned value, so one unsigned compare rejects both edges.
   always_comb begin
      w_dx = '0;
      w_dy = '0;
      case (r_nbr_idx)
         3'd0, 3'd3, 3'd5: w_dx = '1;
         3'd2, 3'd4, 3'd7: w_dx = (X_BITS+2)'(1);
         default:          w_dx = '0;
      endcase
      if (r_nbr_idx <= 3'd2) begin
         w_dy = '1;
      end else if (r_nbr_idx >= 3'd5) begin
         w_dy = (Y_BITS+2)'(1);
      end
      w_nx     = {2'b00, r_cur_x} + w_dx;
      w_ny     = {2'b00, r_cur_y} + w_dy;
      w_nbr_ok = (w_nx < X_LIM) && (w_ny < Y_LIM);
   end

   always_comb begin
      w_push_en   = 1'b0;
      w_push_addr = r_sp[STACK_AW-1:0];
      w_push_data = {w_ny[Y_BITS-1:0], w_nx[X_BITS-1:0]};
      if (r_state == S_IDLE && i_start) begin
         w_push_en   = 1'b1;
         w_push_addr = '0;
         w_push_data = {i_start_y, i_start_x};
      end else if (r_state == S_NBR && w_nbr_ok && !w_full) begin
         w_push_en = 1'b1;
      end
   end

   always_ff @(posedge board_clk) begin
      if (w_push_en) begin
         r_stack[w_push_addr] <= w_push_data;
      end
   end

   always_ff @(posedge board_clk or posedge glob_reset) begin
      if (glob_reset) begin
         r_state        <= S_IDLE;
         r_sp           <= '0;
         r_cur_x        <= '0;
         r_cur_y        <= '0;
         r_nbr_idx      <= '0;
         o_rd_en        <= 1'b0;
         o_rd_x         <= '0;
         o_rd_y         <= '0;
         o_open_strobe  <= 1'b0;
         o_open_x       <= '0;
         o_open_y       <= '0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_hit_mine     <= 1'b0;
         o_overflow     <= 1'b0;
         o_opened_count <= '0;
      end else begin
         o_rd_en       <= 1'b0;
         o_open_strobe <= 1'b0;
         o_done        <= 1'b0;
         if (i_cancel) begin
            r_state <= S_IDLE;
            r_sp    <= '0;
            o_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_sp           <= (STACK_AW+1)'(1);
                     o_hit_mine     <= 1'b0;
                     o_overflow     <= 1'b0;
                     o_opened_count <= '0;
                     o_busy         <= 1'b1;
                     r_state        <= S_POP;
                  end
               end
               S_POP: begin
                  if (r_sp == '0) begin
                     r_state <= S_FIN;
                  end else begin
                     r_sp    <= r_sp - (STACK_AW+1)'(1);
                     r_cur_x <= w_top[X_BITS-1:0];
                     r_cur_y <= w_top[SW-1:X_BITS];
                     o_rd_x  <= w_top[X_BITS-1:0];
                     o_rd_y  <= w_top[SW-1:X_BITS];
                     o_rd_en <= 1'b1;
                     r_state <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  r_state <= S_EVAL;
               end
               S_EVAL: begin
                  // Already-open and flagged cells are skipped; this also absorbs
                  // the duplicate pushes that neighbouring zero cells generate.
                  if (i_rd_cover_val != 2'b00) begin
                     r_state <= S_POP;
                  end else begin
                     o_open_strobe <= 1'b1;
                     o_open_x      <= r_cur_x;
                     o_open_y      <= r_cur_y;
                     if (i_rd_board_val == MINE_VAL) begin
                        o_hit_mine <= 1'b1;
                        r_sp       <= '0;
                        r_state    <= S_FIN;
                     end else begin
                        if (o_opened_count != '1) begin
                           o_opened_count <= o_opened_count + CW'(1);
                        end
                        if (i_rd_board_val == 5'd0) begin
                           r_nbr_idx <= '0;
                           r_state   <= S_NBR;
                        end else begin
                           r_state <= S_POP;
                        end
                     end
                  end
               end
               S_NBR: begin
                  if (w_nbr_ok) begin
                     if (w_full) begin
                        o_overflow <= 1'b1;
                     end else begin
                        r_sp <= r_sp + (STACK_AW+1)'(1);
                     end
                  end
                  r_nbr_idx <= r_nbr_idx + 3'd1;
                  if (r_nbr_idx == 3'd7) begin
                     r_state <= S_POP;
                  end
               end
               S_FIN: begin
                  o_done  <= 1'b1;
                  o_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
